// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bpu_pkg;

  // Two-bit direction counter; the MSB is the taken prediction
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Increment holding at the all-ones value of a width-bit field
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val == max_val) ? val : val + 64'd1;
  endfunction

  // Move the direction counter one step toward the resolved outcome
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    else       return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_pri_enc.sv
// Lowest-index-first priority encoder over an N-bit request vector.
// Latency: combinational.
// Backpressure: none.
module btb_pri_enc #(
  parameter int N    = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Fully-associative BTB with 2-bit direction counters, age-based LRU and stats.
// Latency: lookup combinational from current state; update visible the cycle after ex_valid.
// Backpressure: none; every ex_valid is absorbed unless flush drops it in the same cycle.
module btb_assoc
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  parameter int AGE_W   = 8,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_hit,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_taken,
  output logic              ex_hit,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0]  tag    [ENTRIES];
  logic [ADDR_W-1:0]  target [ENTRIES];
  ctr_t               ctr    [ENTRIES];
  logic [AGE_W-1:0]   age    [ENTRIES];

  logic [ENTRIES-1:0] if_match, ex_match;
  logic [IDX_W-1:0]   if_idx, ex_idx, inv_idx, old_idx, upd_idx;
  logic               if_any, ex_any, inv_any;
  logic [AGE_W-1:0]   old_age;
  logic               mispredict;

  // Tag compare for both ports against the current (pre-update) state
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if_match[i] = valid[i] && (tag[i] == if_pc);
      ex_match[i] = valid[i] && (tag[i] == ex_pc);
    end
  end

  btb_pri_enc #(.N(ENTRIES)) u_if_enc  (.req(if_match), .idx(if_idx),  .any(if_any));
  btb_pri_enc #(.N(ENTRIES)) u_ex_enc  (.req(ex_match), .idx(ex_idx),  .any(ex_any));
  btb_pri_enc #(.N(ENTRIES)) u_inv_enc (.req(~valid),   .idx(inv_idx), .any(inv_any));

  // Oldest entry, lowest index on ties; only consulted when every slot is valid
  always_comb begin
    old_idx = '0;
    old_age = age[0];
    for (int i = 1; i < ENTRIES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  // Pick the slot to write and decide whether the stored prediction was wrong
  always_comb begin
    upd_idx    = ex_any ? ex_idx : (inv_any ? inv_idx : old_idx);
    mispredict = ex_any ? (ctr[ex_idx][1] != ex_taken) : ex_taken;
  end

  assign if_hit         = if_any;
  assign if_pred_taken  = if_any && ctr[if_idx][1];
  assign if_pred_target = if_any ? target[if_idx] : '0;
  assign ex_hit         = ex_any;

  // Entry state: flush invalidates everything and swallows a coincident update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_SNT;
        age[i]    <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else if (ex_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == upd_idx) begin
          age[i] <= '0;
          if (ex_any) begin
            ctr[i] <= ctr_next(ctr[i], ex_taken);
            if (ex_taken) target[i] <= ex_target;
          end else begin
            valid[i]  <= 1'b1;
            tag[i]    <= ex_pc;
            target[i] <= ex_target;
            ctr[i]    <= ex_taken ? CTR_WT : CTR_WNT;
          end
        end else if (valid[i]) begin
          age[i] <= AGE_W'(sat_inc(64'(age[i]), AGE_W));
        end
      end
    end
  end

  // Saturating statistics; survive flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else if (ex_valid && !flush) begin
      stat_lookups <= STAT_W'(sat_inc(64'(stat_lookups), STAT_W));
      if (mispredict) stat_mispredicts <= STAT_W'(sat_inc(64'(stat_mispredicts), STAT_W));
    end
  end

endmodule
